lif_neuron_core: RTL and testbench

//   Leaky integrate-and-fire neuron datapath instantiated inside tt_um_crockpotveggies_neuron.

---
 rtl/lif_neuron_core.sv | 131 +++++++++++++
 tb/tb_lif_neuron_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: shift-leak integration, saturating membrane, registered spike
// and refractory hold-off. Define LIF_SPIKE_COUNT_EN to build the wrapping spike counter.
module lif_neuron_core #(
   parameter int unsigned W          = 8,
   parameter int unsigned LEAK_SHIFT = 1,
   parameter int unsigned REFRAC     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         in_valid,
   input  logic [W-1:0] current,
   input  logic [W-1:0] threshold,
   output logic         spike,
   output logic [W-1:0] membrane,
   output logic         refractory,
   output logic [7:0]   spike_count
);

   localparam int unsigned CntW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

   typedef enum logic [0:0] {StIntegrate, StRefractory} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    membrane_q, membrane_d;
   logic            spike_q, spike_d;
   logic            refractory_q, refractory_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [W-1:0]    cur;
   logic [W-1:0]    decayed;
   logic [W:0]      sum;
   logic [W-1:0]    next_pot;
   logic            fire;

   // Integration datapath; the extra sum bit catches overflow for saturation.
   always_comb begin
      cur      = in_valid ? current : '0;
      decayed  = membrane_q - (membrane_q >> LEAK_SHIFT);
      sum      = {1'b0, decayed} + {1'b0, cur};
      next_pot = sum[W] ? {W{1'b1}} : sum[W-1:0];
      fire     = (threshold != '0) && (next_pot >= threshold);
   end

   always_comb begin
      state_d      = state_q;
      membrane_d   = membrane_q;
      refractory_d = refractory_q;
      cnt_d        = cnt_q;
      spike_d      = 1'b0;
      if (ena) begin
         case (state_q)
            StIntegrate: begin
               if (fire) begin
                  membrane_d = '0;
                  spike_d    = 1'b1;
                  if (REFRAC > 0) begin
                     state_d      = StRefractory;
                     cnt_d        = CntW'(REFRAC);
                     refractory_d = 1'b1;
                  end
               end else begin
                  membrane_d = next_pot;
               end
            end
            StRefractory: begin
               // Inputs are discarded while refractory; membrane stays clamped at zero.
               membrane_d = '0;
               if (cnt_q <= CntW'(1)) begin
                  state_d      = StIntegrate;
                  refractory_d = 1'b0;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            default: begin
               state_d      = StIntegrate;
               membrane_d   = '0;
               refractory_d = 1'b0;
               cnt_d        = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIntegrate;
         membrane_q   <= '0;
         spike_q      <= 1'b0;
         refractory_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         membrane_q   <= membrane_d;
         spike_q      <= spike_d;
         refractory_q <= refractory_d;
         cnt_q        <= cnt_d;
      end
   end

   assign spike      = spike_q;
   assign membrane   = membrane_q;
   assign refractory = refractory_q;

`ifdef LIF_SPIKE_COUNT_EN
   logic [7:0] count_q, count_d;

   // spike_d is already gated by ena, so the count freezes with the rest of the state.
   always_comb begin
      count_d = count_q;
      if (spike_d) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign spike_count = count_q;
`else
   assign spike_count = 8'd0;
`endif

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed self-checking bench for lif_neuron_core (W=8, LEAK_SHIFT=1, REFRAC=4).
// Expected spike_count follows LIF_SPIKE_COUNT_EN.
module tb_lif_neuron_core;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       in_valid;
   logic [7:0] current;
   logic [7:0] threshold;
   logic       spike;
   logic [7:0] membrane;
   logic       refractory;
   logic [7:0] spike_count;

   int vectors;
   int miscompares;

   lif_neuron_core #(
      .W         (8),
      .LEAK_SHIFT(1),
      .REFRAC    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_valid   (in_valid),
      .current    (current),
      .threshold  (threshold),
      .spike      (spike),
      .membrane   (membrane),
      .refractory (refractory),
      .spike_count(spike_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed observation: {spike, refractory, membrane, spike_count}.
   function automatic logic [17:0] obs();
      return {spike, refractory, membrane, spike_count};
   endfunction

   function automatic logic [7:0] expc(input int n);
`ifdef LIF_SPIKE_COUNT_EN
      return n[7:0];
`else
      return 8'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ena       = 1'b0;
      in_valid  = 1'b0;
      current   = 8'd0;
      threshold = 8'd0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [17:0] exp;
      rst_n     = 1'b0;
      ena       = 1'b1;
      in_valid  = 1'b1;
      current   = 8'd200;
      threshold = 8'd100;
      tick();
      exp = {1'b0, 1'b0, 8'd0, 8'd0};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL reset_hold got %h exp %h", obs(), exp);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL reset_release got %h exp %h", obs(), exp);
      end
   endtask

   task automatic test_integrate_leak();
      logic [7:0]  mem_tab [8] = '{8'd40, 8'd60, 8'd70, 8'd75, 8'd78, 8'd79, 8'd80, 8'd80};
      logic [17:0] exp;
      do_reset();
      ena       = 1'b1;
      threshold = 8'd100;
      in_valid  = 1'b1;
      current   = 8'd40;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = {1'b0, 1'b0, mem_tab[i], 8'd0};
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL leak_step%0d got %h exp %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_fire_refractory();
      logic [17:0] exp;
      int          ph;
      do_reset();
      ena       = 1'b1;
      threshold = 8'd100;
      in_valid  = 1'b1;
      current   = 8'd200;
      for (int k = 1; k <= 15; k++) begin
         tick();
         ph  = (k - 1) % 5;
         exp = {ph == 0, ph != 4, 8'd0, expc((k - 1) / 5 + 1)};
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL fire_edge%0d got %h exp %h", k, obs(), exp);
         end
      end
   endtask

   task automatic test_saturation();
      logic [17:0] exp;
      do_reset();
      ena       = 1'b1;
      threshold = 8'd0;
      in_valid  = 1'b1;
      current   = 8'd255;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp = {1'b0, 1'b0, 8'd255, 8'd0};
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sat_step%0d got %h exp %h", i, obs(), exp);
         end
      end
   endtask

   task automatic test_ena_freeze();
      logic [17:0] exp;
      int          high_cycles;
      do_reset();
      ena         = 1'b1;
      threshold   = 8'd100;
      in_valid    = 1'b1;
      current     = 8'd200;
      high_cycles = 0;
      tick();
      if (refractory) high_cycles++;
      exp = {1'b1, 1'b1, 8'd0, expc(1)};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL frz_fire got %h exp %h", obs(), exp);
      end
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (refractory) high_cycles++;
         exp = {1'b0, 1'b1, 8'd0, expc(1)};
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL frz_off%0d got %h exp %h", i, obs(), exp);
         end
      end
      ena = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i % 2 == 0);
         tick();
         if (refractory) high_cycles++;
         exp = {1'b0, i != 3, 8'd0, expc(1)};
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL frz_on%0d got %h exp %h", i, obs(), exp);
         end
      end
      vectors++;
      if (high_cycles !== 7) begin
         miscompares++;
         $display("FAIL frz_refrac_len got %0d exp %0d", high_cycles, 7);
      end
      in_valid = 1'b0;
      tick();
      exp = {1'b0, 1'b0, 8'd0, expc(1)};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL frz_exit got %h exp %h", obs(), exp);
      end
   endtask

   task automatic test_async_reset();
      logic [17:0] exp;
      do_reset();
      ena       = 1'b1;
      threshold = 8'd100;
      in_valid  = 1'b1;
      current   = 8'd200;
      tick();
      tick();
      exp = {1'b0, 1'b1, 8'd0, expc(1)};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL ares_pre got %h exp %h", obs(), exp);
      end
      #2;
      rst_n = 1'b0;
      #1;
      exp = {1'b0, 1'b0, 8'd0, 8'd0};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL ares_immediate got %h exp %h", obs(), exp);
      end
      #2;
      rst_n = 1'b1;
      tick();
      exp = {1'b1, 1'b1, 8'd0, expc(1)};
      vectors++;
      if (obs() !== exp) begin
         miscompares++;
         $display("FAIL ares_refire got %h exp %h", obs(), exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      ena         = 1'b0;
      in_valid    = 1'b0;
      current     = 8'd0;
      threshold   = 8'd0;
      test_reset();
      test_integrate_leak();
      test_fire_refractory();
      test_saturation();
      test_ena_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
